// File: rtl/instr_feeder.sv
// Fetch stage for the 16-bit multicycle processor: walks a synchronous-read ROM,
// presents each word on DIN, pulses Run, and waits for Done before the next fetch.
module instr_feeder #(
  parameter int unsigned AW         = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LAST_ADDR  = 255,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Enable,
  input  logic          StepMode,
  input  logic          Step,
  output logic [AW-1:0] MemAddr,
  input  logic [15:0]   MemQ,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic [15:0]   InstrCount,
  output logic          Halted,
  output logic          Error
);

  localparam int unsigned WD_W = 8;
  localparam logic [AW-1:0]   START_PC = AW'(START_ADDR);
  localparam logic [AW-1:0]   LAST_PC  = AW'(LAST_ADDR);
  localparam logic [WD_W-1:0] WD_TRIP  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   pc_n;
  logic [15:0]     din_n;
  logic            run_n;
  logic [15:0]     cnt_n;
  logic            halted_n;
  logic            error_n;
  logic [WD_W-1:0] wd, wd_n;

  // State and all output registers; MemAddr always mirrors the next PC.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      PC         <= START_PC;
      MemAddr    <= START_PC;
      DIN        <= 16'h0000;
      Run        <= 1'b0;
      InstrCount <= 16'h0000;
      Halted     <= 1'b0;
      Error      <= 1'b0;
      wd         <= '0;
    end else begin
      state      <= state_n;
      PC         <= pc_n;
      MemAddr    <= pc_n;
      DIN        <= din_n;
      Run        <= run_n;
      InstrCount <= cnt_n;
      Halted     <= halted_n;
      Error      <= error_n;
      wd         <= wd_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    pc_n     = PC;
    din_n    = DIN;
    cnt_n    = InstrCount;
    halted_n = Halted;
    error_n  = Error;
    wd_n     = wd;

    case (state)
      S_IDLE: begin
        if (Halted) begin
          state_n = S_HALT;
        end else if (Enable && (!StepMode || Step)) begin
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        state_n = S_LOAD;
      end
      S_LOAD: begin
        din_n   = MemQ;
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
        // Watchdog holds the number of cycles elapsed since the issue cycle.
        wd_n    = WD_W'(1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (Done) begin
          cnt_n = InstrCount + 16'd1;
          if (PC == LAST_PC) begin
            halted_n = 1'b1;
            state_n  = S_HALT;
          end else begin
            pc_n    = PC + AW'(1);
            state_n = S_IDLE;
          end
        end else if (wd >= WD_TRIP) begin
          error_n  = 1'b1;
          halted_n = 1'b1;
          state_n  = S_HALT;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    run_n = (state_n == S_ISSUE);
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: three parameterisations, each with a ROM
// and a small processor model that returns Done 2 (mv/mvt) or 4 (add/sub) cycles after Run.
module tb_instr_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] rst, en, sm, stp, kill, spur;
  logic [15:0] rom [3][256];

  logic        run_w    [3];
  logic [15:0] din_w    [3];
  logic [7:0]  pc_w     [3];
  logic [7:0]  maddr_w  [3];
  logic [15:0] cnt_w    [3];
  logic        halted_w [3];
  logic        err_w    [3];
  logic [15:0] r0_w     [3];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned W     = (g == 2) ? 2 : 8;
    localparam int unsigned START = (g == 2) ? 3 : 0;
    localparam int unsigned LAST  = (g == 1) ? 3 : 1;

    logic [W-1:0] mem_addr, pc;
    logic [15:0]  memq, din, cnt, r0;
    logic         run, done, halted, err;
    int           cd;

    instr_feeder #(.AW(W), .START_ADDR(START), .LAST_ADDR(LAST), .TIMEOUT(15)) u_dut (
      .Clock(clk), .Reset(rst[g]), .Enable(en[g]), .StepMode(sm[g]), .Step(stp[g]),
      .MemAddr(mem_addr), .MemQ(memq), .DIN(din), .Run(run), .Done(done),
      .PC(pc), .InstrCount(cnt), .Halted(halted), .Error(err)
    );

    always @(posedge clk) memq <= rom[g][8'(mem_addr)];

    // Processor model: latches the instruction on Run, signals Done when cd hits 1.
    always @(posedge clk or posedge rst[g]) begin
      if (rst[g]) begin
        cd <= 0;
        r0 <= 16'h0000;
      end else if (run) begin
        cd <= (din[15:13] < 3'd2) ? 2 : 4;
        if (din[11:9] == 3'd0) begin
          if (din[15:13] == 3'd0) r0 <= {7'd0, din[8:0]};
          else if (din[15:13] == 3'd2) r0 <= r0 + {7'd0, din[8:0]};
        end
      end else if (cd != 0) begin
        cd <= cd - 1;
      end
    end

    assign done = ((cd == 1) && !kill[g]) || spur[g];

    assign run_w[g]    = run;
    assign din_w[g]    = din;
    assign pc_w[g]     = 8'(pc);
    assign maddr_w[g]  = 8'(mem_addr);
    assign cnt_w[g]    = cnt;
    assign halted_w[g] = halted;
    assign err_w[g]    = err;
    assign r0_w[g]     = r0;
  end

  typedef struct {
    int          inst;
    logic [15:0] din;
    logic [7:0]  pc;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  int rel = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int inst, input logic [15:0] d, input logic [7:0] p, input int c);
    exp_t e;
    e.inst = inst; e.din = d; e.pc = p; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic release_rst(input int g);
    @(negedge clk);
    rst[g] = 1'b0;
    rel = cyc;
  endtask

  task automatic wait_halt(input int g, output int hc);
    int i = 0;
    while (!halted_w[g] && i < 300) begin
      @(negedge clk);
      i++;
    end
    hc = cyc - rel;
  endtask

  task automatic chk_reset(input int g);
    chk("rst_pc", 32'(pc_w[g]), (g == 2) ? 32'd3 : 32'd0);
    chk("rst_memaddr", 32'(maddr_w[g]), (g == 2) ? 32'd3 : 32'd0);
    chk("rst_din", 32'(din_w[g]), 32'd0);
    chk("rst_run", 32'(run_w[g]), 32'd0);
    chk("rst_count", 32'(cnt_w[g]), 32'd0);
    chk("rst_halted", 32'(halted_w[g]), 32'd0);
    chk("rst_error", 32'(err_w[g]), 32'd0);
  endtask

  // Monitor: every Run pulse must match the oldest expected issue.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (run_w[g]) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_run: inst %0d got Run with DIN %h, required no Run", g, din_w[g]);
        end else begin
          e = q.pop_front();
          chk("run_inst", 32'(g), 32'(e.inst));
          chk("run_din", 32'(din_w[g]), 32'(e.din));
          chk("run_pc", 32'(pc_w[g]), 32'(e.pc));
          chk("run_memaddr", 32'(maddr_w[g]), 32'(e.pc));
          chk("run_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int hc;
    int i;
    rst = 3'b111; en = '0; sm = '0; stp = '0; kill = '0; spur = '0;
    for (int g = 0; g < 3; g++)
      for (int a = 0; a < 256; a++) rom[g][a] = 16'h0000;
    rom[0][0] = 16'h1005; rom[0][1] = 16'h5003;
    rom[1][0] = 16'h1005; rom[1][1] = 16'h5003; rom[1][2] = 16'h1203; rom[1][3] = 16'h5001;
    rom[2][3] = 16'h1001; rom[2][0] = 16'h1002; rom[2][1] = 16'h1003;

    // Free-run two-instruction program, halt after address 1.
    en[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(2);
    release_rst(0);
    push(0, 16'h1005, 8'd0, rel + 3);
    push(0, 16'h5003, 8'd1, rel + 9);
    wait_halt(0, hc);
    chk("t1_halt_cycle", 32'(hc), 32'd14);
    chk("t1_count", 32'(cnt_w[0]), 32'd2);
    chk("t1_halted", 32'(halted_w[0]), 32'd1);
    chk("t1_error", 32'(err_w[0]), 32'd0);
    chk("t1_pc", 32'(pc_w[0]), 32'd1);
    chk("t1_r0", 32'(r0_w[0]), 32'd8);
    chk("t1_din_held", 32'(din_w[0]), 32'h5003);

    // Single-step: three Step pulses 20 cycles apart.
    en[1] = 1'b1; sm[1] = 1'b1;
    @(negedge clk);
    chk_reset(1);
    release_rst(1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      stp[1] = 1'b1;
      push(1, rom[1][k], 8'(k), cyc + 3);
      @(negedge clk);
      stp[1] = 1'b0;
      repeat (19) @(negedge clk);
    end
    chk("t2_pc", 32'(pc_w[1]), 32'd3);
    chk("t2_halted", 32'(halted_w[1]), 32'd0);
    chk("t2_count", 32'(cnt_w[1]), 32'd3);
    chk("t2_error", 32'(err_w[1]), 32'd0);

    // Spurious Done while parked in IDLE.
    en[1] = 1'b0;
    @(negedge clk);
    spur[1] = 1'b1;
    @(negedge clk);
    spur[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_count", 32'(cnt_w[1]), 32'd3);
    chk("t4_pc", 32'(pc_w[1]), 32'd3);

    // Watchdog: Done never arrives.
    rst[1] = 1'b1; kill[1] = 1'b1; en[1] = 1'b1; sm[1] = 1'b0;
    release_rst(1);
    push(1, 16'h1005, 8'd0, rel + 3);
    i = 0;
    while (!err_w[1] && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("t3_error_cycle", 32'(cyc - rel), 32'd18);
    chk("t3_error", 32'(err_w[1]), 32'd1);
    chk("t3_halted", 32'(halted_w[1]), 32'd1);
    chk("t3_count", 32'(cnt_w[1]), 32'd0);
    repeat (10) @(negedge clk);

    // Reset during WAIT of the second instruction, then restart.
    rst[1] = 1'b1; kill[1] = 1'b0;
    release_rst(1);
    push(1, 16'h1005, 8'd0, rel + 3);
    push(1, 16'h5003, 8'd1, rel + 9);
    while (cyc - rel < 11) @(negedge clk);
    @(posedge clk);
    #2 rst[1] = 1'b1;
    #1 chk_reset(1);
    release_rst(1);
    push(1, 16'h1005, 8'd0, rel + 3);
    push(1, 16'h5003, 8'd1, rel + 9);
    push(1, 16'h1203, 8'd2, rel + 17);
    push(1, 16'h5001, 8'd3, rel + 23);
    wait_halt(1, hc);
    chk("t5_halt_cycle", 32'(hc), 32'd28);
    chk("t5_count", 32'(cnt_w[1]), 32'd4);
    chk("t5_pc", 32'(pc_w[1]), 32'd3);
    chk("t5_error", 32'(err_w[1]), 32'd0);

    // Narrow address space with wraparound: 3 -> 0 -> 1.
    en[2] = 1'b1;
    release_rst(2);
    push(2, 16'h1001, 8'd3, rel + 3);
    push(2, 16'h1002, 8'd0, rel + 9);
    push(2, 16'h1003, 8'd1, rel + 15);
    wait_halt(2, hc);
    chk("t6_halt_cycle", 32'(hc), 32'd18);
    chk("t6_count", 32'(cnt_w[2]), 32'd3);
    chk("t6_pc", 32'(pc_w[2]), 32'd1);
    chk("t6_halted", 32'(halted_w[2]), 32'd1);
    chk("t6_error", 32'(err_w[2]), 32'd0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Upstream fetch stage for the 16-bit multicycle processor. It walks a program stored in a synchronous-read instruction ROM, presents each word on the processor's DIN, and pulses Run.
- It waits for the processor's Done before fetching the next word.
- It supports free-run and single-step modes, halts at a programmed last address, and includes a watchdog that trips if Done never arrives.

Parameters:
- AW, 8, ROM address width.
- START_ADDR, 0, first fetch address after reset.
- LAST_ADDR, 255, address of final instruction; halt after its Done.
- TIMEOUT, 15, max cycles in WAIT before watchdog error (range 1..255).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  level; 1 permits fetching, 0 parks in IDLE between instructions.
- StepMode  in  1  1 = single-step; one instruction issued per Step pulse.
- Step  in  1  single-cycle pulse; ignored unless StepMode=1 and state IDLE.
- MemAddr  out  AW  ROM address.
- MemQ  in  16  ROM read data, valid one cycle after MemAddr is sampled.
- DIN  out  16  instruction word to processor (registered).
- Run  out  1  one-cycle issue strobe to processor.
- Done  in  1  processor completion, combinational from processor T1/T3.
- PC  out  AW  address of instruction currently in flight or next to fetch.
- InstrCount  out  16  retired-instruction count (Done pulses accepted).
- Halted  out  1  1 after LAST_ADDR retires or watchdog trips; sticky.
- Error  out  1  watchdog tripped; sticky.

Behaviour:
- Reset (async, immediate): state IDLE; PC=START_ADDR; MemAddr=START_ADDR; DIN=0; Run=0; InstrCount=0; Halted=0; Error=0; watchdog counter=0.
- States: IDLE, ADDR, LOAD, ISSUE, WAIT, HALT.
- IDLE:
  - If Halted, go to HALT.
  - Otherwise, if Enable=1 and (StepMode=0 or Step=1), go to ADDR.
- ADDR: MemAddr=PC driven; ROM samples at this edge; go to LOAD.
- LOAD: DIN<=MemQ at this edge; go to ISSUE.
- ISSUE:
  - Run=1 for exactly this cycle. DIN is stable (processor in T0 loads IR and advances).
  - Clear watchdog; go to WAIT.
- WAIT:
  - Run=0; DIN held. Watchdog increments each cycle.
  - On Done=1: InstrCount+=1 (wraps at 16'hFFFF to 0).
    - If PC==LAST_ADDR, set Halted=1 and go to HALT.
    - Otherwise PC+=1 (wraps modulo 2^AW) and go to IDLE.
  - If watchdog reaches TIMEOUT with Done=0: Error=1, Halted=1, go to HALT. Done in the same cycle as the timeout wins: retire normally, no error.
- HALT: Run=0, all outputs frozen; leaves only via Reset.
- Run is never asserted outside ISSUE. Done observed outside WAIT is ignored (no count, no PC change).
- Minimum issue-to-issue spacing, free-run: 1-step instructions (mv/mvt) take 6 cycles; 3-step (add/sub) take 8.
- Enable dropped mid-instruction: the current instruction completes through WAIT; the block then parks in IDLE.
- Step held high in step mode issues one instruction per IDLE visit (level acts as repeat).
- MemAddr holds PC in all states (ROM read is harmless).
- Processor reset is independent. Asserting Reset here mid-WAIT abandons the instruction; the system must reset the processor concurrently.

Test Plan:
- ROM[0]=16'h1005 (mv r0,#5), ROM[1]=16'h5003 (add r0,#3), LAST_ADDR=1, free-run -> Run pulses at cycles 3 and 9 after reset release, DIN matches ROM words, InstrCount=2, Halted=1, Error=0, processor r0=8.
- StepMode=1, three Step pulses 20 cycles apart over a 4-word program -> exactly three Run pulses, each 3 cycles after its Step, PC=3, Halted=0.
- Done tied 0, TIMEOUT=15 -> single Run pulse; Error=1 and Halted=1 exactly 15 cycles after ISSUE; no further Run.
- Spurious Done pulse while in IDLE (Enable=0) -> InstrCount and PC unchanged.
- Reset asserted during WAIT of the second instruction -> all outputs to reset values within the same cycle; after release, fetching restarts at START_ADDR.
- AW=2, START_ADDR=3, LAST_ADDR=1 -> PC sequence 3,0,1, then Halted=1, InstrCount=3.
